// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds, occupancy count, sticky error flags and optional first-word-fall-through.
`timescale 1ns/1ps
module sync_fifo_thresh #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 63,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_wr_ptr_inc;
  logic [PW-1:0]    w_rd_ptr_inc;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             r_full;
  logic             r_empty;
  logic             r_af;
  logic             r_ae;
  logic             r_ovf;
  logic             r_udf;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // Acceptance looks only at the registered flags, so a pop on a full FIFO
  // never frees room for a write in the same cycle.
  assign w_wr_acc = wr_en && !r_full;
  assign w_rd_acc = rd_en && !r_empty;

  assign w_wr_ptr_inc = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  always_comb begin
    w_count_next = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == '0);
      r_af    <= (w_count_next >= CW'(AF_THRESH));
      r_ae    <= (w_count_next <= CW'(AE_THRESH));
      // A new error event outranks a coincident clear.
      if (wr_en && r_full) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end
      if (rd_en && r_empty) begin
        r_udf <= 1'b1;
      end else if (clr_err) begin
        r_udf <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = r_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] r_dout;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dout <= '0;
        end else if (w_rd_acc) begin
          r_dout <= r_mem[r_rd_ptr];
        end
      end
      assign data_out = r_dout;
    end
  endgenerate

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Bench for sync_fifo_thresh: a standard and an FWFT instance share stimulus and
// are checked every cycle against one queue-based model, plus literal expectations.
`timescale 1ns/1ps
module tb_sync_fifo_thresh;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  data_in = '0;

  logic [W-1:0]  s_dout, f_dout;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [CW-1:0] s_count, f_count;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Reference model: contents as a queue, plus error flags and the last popped word.
  logic [W-1:0] q[$];
  bit           m_ovf = 1'b0;
  bit           m_udf = 1'b0;
  logic [W-1:0] m_std_dout = '0;

  always #5 clk = ~clk;

  sync_fifo_thresh #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_thresh #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
      m_std_dout = '0;
    end else begin
      automatic bit was_full  = (q.size() == D);
      automatic bit was_empty = (q.size() == 0);
      if (wr_en && was_full) m_ovf = 1'b1;
      else if (clr_err)      m_ovf = 1'b0;
      if (rd_en && was_empty) m_udf = 1'b1;
      else if (clr_err)       m_udf = 1'b0;
      if (rd_en && !was_empty) m_std_dout = q.pop_front();
      if (wr_en && !was_full)  q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      automatic int n = q.size();
      check("count_std",  int'(s_count), n);
      check("count_fwft", int'(f_count), n);
      check("full",       int'({s_full, f_full}),   (n == D)  ? 3 : 0);
      check("empty",      int'({s_empty, f_empty}), (n == 0)  ? 3 : 0);
      check("almost_full",  int'({s_af, f_af}),     (n >= AF) ? 3 : 0);
      check("almost_empty", int'({s_ae, f_ae}),     (n <= AE) ? 3 : 0);
      check("overflow",   int'({s_ovf, f_ovf}),     m_ovf ? 3 : 0);
      check("underflow",  int'({s_udf, f_udf}),     m_udf ? 3 : 0);
      check("dout_std",   int'(s_dout), int'(m_std_dout));
      check("dout_fwft",  int'(f_dout), (n != 0) ? int'(q[0]) : 0);
    end
  end

  // Drive one cycle's inputs, then return at the following falling edge.
  task automatic cyc(input bit wr, input logic [W-1:0] d, input bit rd, input bit clr);
    wr_en = wr; data_in = d; rd_en = rd; clr_err = clr;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // FWFT presentation
    cyc(1, 8'h5A, 0, 0);
    check("fwft_first", int'(f_dout), 'h5A);
    check("fwft_nonempty", int'(f_empty), 0);
    cyc(0, 8'h00, 1, 0);
    check("fwft_pop_empty", int'(f_empty), 1);
    check("fwft_pop_zero", int'(f_dout), 0);
    check("std_pop_val", int'(s_dout), 'h5A);
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    check("fwft_head", int'(f_dout), 'h01);
    cyc(0, 8'h00, 1, 0);
    check("fwft_next", int'(f_dout), 'h02);
    cyc(0, 8'h00, 1, 0);

    // Fill and drain with threshold crossings
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'h11 + 8'(i), 0, 0);
      check("fill_count", int'(s_count), i + 1);
      check("fill_ae", int'(s_ae), (i + 1 <= 1) ? 1 : 0);
      check("fill_af", int'(s_af), (i + 1 >= 4) ? 1 : 0);
      check("fill_full", int'(s_full), (i == 4) ? 1 : 0);
    end
    cyc(1, 8'hAA, 0, 0);
    check("ovf_count", int'(s_count), 5);
    check("ovf_flag", int'(s_ovf), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'h00, 1, 0);
      check("drain_data", int'(s_dout), 'h11 + i);
    end
    check("drain_empty", int'(s_empty), 1);
    cyc(0, 8'h00, 1, 0);
    check("udf_flag", int'(s_udf), 1);
    check("udf_hold_dout", int'(s_dout), 'h15);
    cyc(0, 8'h00, 0, 1);
    check("clr_ovf", int'(s_ovf), 0);
    check("clr_udf", int'(s_udf), 0);

    // Boundary simultaneity
    for (int i = 0; i < 5; i++) cyc(1, 8'h21 + 8'(i), 0, 0);
    cyc(1, 8'hBB, 0, 1);
    check("clr_vs_set", int'(s_ovf), 1);
    cyc(1, 8'hCC, 1, 0);
    check("full_both_count", int'(s_count), 4);
    check("full_both_ovf", int'(s_ovf), 1);
    check("full_both_data", int'(s_dout), 'h21);
    cyc(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1, 0);
      check("bnd_drain", int'(s_dout), 'h22 + i);
    end
    cyc(1, 8'h33, 1, 0);
    check("empty_both_count", int'(s_count), 1);
    check("empty_both_udf", int'(s_udf), 1);
    cyc(1, 8'h34, 0, 1);
    cyc(1, 8'h35, 1, 0);
    check("mid_both_count", int'(s_count), 2);
    check("mid_both_data", int'(s_dout), 'h33);
    cyc(0, 8'h00, 1, 0);
    check("mid_order1", int'(s_dout), 'h34);
    cyc(0, 8'h00, 1, 0);
    check("mid_order2", int'(s_dout), 'h35);

    // Wrap-around with interleaved pairs
    for (int i = 0; i < 12; i++) begin
      cyc(1, 8'(i), 0, 0);
      cyc(0, 8'h00, 1, 0);
      check("wrap_data", int'(s_dout), i);
    end

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-traffic at count=3
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 8'h40 + 8'(i), 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h50, 0, 0);
    check("pre_rst_count", int'(s_count), 3);
    #2 rst = 1'b1;
    #1;
    check("rst_count", int'({s_count, f_count}), 0);
    check("rst_empty", int'({s_empty, f_empty}), 3);
    check("rst_ae", int'({s_ae, f_ae}), 3);
    check("rst_full_af", int'({s_full, f_full, s_af, f_af}), 0);
    check("rst_dout", int'({s_dout, f_dout}), 0);
    check("rst_err", int'({s_ovf, s_udf, f_ovf, f_udf}), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 8'h77, 0, 0);
    check("post_rst_write", int'(f_dout), 'h77);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
